ctrl_seq_player: RTL and testbench

//  Programmable control-word sequencer for the single-cycle CPU. Replaces hand-written
//  tb drive of PCSel/EnWri/ALUsrc/WB/MRW/IMMXSel with a table of DEPTH entries.

---
 rtl/ctrl_seq_player.sv | 206 ++++++++++++++++++++
 tb/tb_ctrl_seq_player.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_player.sv
// ctrl_seq_player: table-driven control-word sequencer feeding the single-cycle CPU control inputs.
// Optional breakpoint/HALT support is compiled in when CTRL_SEQ_BRK_EN is defined.
module ctrl_seq_player #(
  parameter int DEPTH = 16,
  parameter int HOLD_W = 8,
  parameter int CW_W = 7,
  parameter int STAT_W = 4,
  parameter logic [CW_W-1:0] RESET_CW = 7'h08,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   WrEn,
  input  logic [AW-1:0]          WrAddr,
  input  logic [CW_W+HOLD_W-1:0] WrData,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Loop,
  input  logic [AW-1:0]          LastIdx,
  input  logic [STAT_W-1:0]      Status,
`ifdef CTRL_SEQ_BRK_EN
  input  logic [STAT_W-1:0]      BrkMask,
  input  logic [STAT_W-1:0]      BrkVal,
  output logic                   BrkHit,
`endif
  output logic [CW_W-1:0]        CtrlWord,
  output logic [AW-1:0]          Index,
  output logic                   Busy,
  output logic                   Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef CTRL_SEQ_BRK_EN
  localparam logic [1:0] S_HALT = 2'd3;
  // EnWri and MRW are the only bits that change architectural state.
  localparam logic [CW_W-1:0] WRITE_BITS = 7'b010_0100;
`endif

  logic [CW_W+HOLD_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     last_q, last_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic                   load;
  logic [AW-1:0]          load_idx;
  logic [CW_W+HOLD_W-1:0] load_word;
  logic [AW-1:0]          last_in;

`ifdef CTRL_SEQ_BRK_EN
  logic [CW_W-1:0] cur_q, cur_d;
  logic            brk_hit_q, brk_hit_d;
  logic            resume_q, resume_d;
  logic            brk_fire;
`else
  logic unused_status;
  assign unused_status = ^Status;
`endif

  always_ff @(posedge Clock) begin
    if (WrEn) mem_q[WrAddr] <= WrData;
  end

  always_comb begin
    last_in = LastIdx;
    if (int'(LastIdx) > DEPTH - 1) last_in = AW'(DEPTH - 1);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    cw_d      = cw_q;
    load      = 1'b0;
    load_idx  = '0;
    load_word = '0;
`ifdef CTRL_SEQ_BRK_EN
    cur_d     = cur_q;
    brk_hit_d = brk_hit_q;
    resume_d  = resume_q;
    brk_fire  = (state_q == S_RUN) && !resume_q && (BrkMask != '0) &&
                ((Status & BrkMask) == (BrkVal & BrkMask));
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          last_d  = last_in;
          load    = 1'b1;
        end
      end
      S_RUN: begin
`ifdef CTRL_SEQ_BRK_EN
        resume_d = 1'b0;
        if (brk_fire) begin
          // Index and count freeze; the breaking cycle is not counted.
          state_d   = S_HALT;
          cw_d      = cur_q & ~WRITE_BITS;
          brk_hit_d = 1'b1;
        end else
`endif
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (idx_q < last_q) begin
          load     = 1'b1;
          load_idx = idx_q + AW'(1);
        end else if (Loop) begin
          load = 1'b1;
        end else begin
          state_d = S_DONE;
          cw_d    = RESET_CW;
        end
      end
`ifdef CTRL_SEQ_BRK_EN
      S_HALT: begin
        if (Start) begin
          state_d   = S_RUN;
          cw_d      = cur_q;
          brk_hit_d = 1'b0;
          resume_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cw_d    = RESET_CW;
      end
    endcase

    if (load) begin
      load_word = mem_q[load_idx];
      idx_d     = load_idx;
      cw_d      = load_word[CW_W-1:0];
      cnt_d     = load_word[CW_W +: HOLD_W];
`ifdef CTRL_SEQ_BRK_EN
      cur_d     = load_word[CW_W-1:0];
`endif
    end

    // Stop overrides everything except Reset, including a same-cycle Start.
    if (Stop) begin
      state_d = S_IDLE;
      cw_d    = RESET_CW;
      idx_d   = '0;
`ifdef CTRL_SEQ_BRK_EN
      brk_hit_d = 1'b0;
      resume_d  = 1'b0;
`endif
    end

`ifdef CTRL_SEQ_BRK_EN
    busy_d = (state_d == S_RUN) || (state_d == S_HALT);
`else
    busy_d = (state_d == S_RUN);
`endif
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      cw_q    <= RESET_CW;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CTRL_SEQ_BRK_EN
      cur_q     <= RESET_CW;
      brk_hit_q <= 1'b0;
      resume_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CTRL_SEQ_BRK_EN
      cur_q     <= cur_d;
      brk_hit_q <= brk_hit_d;
      resume_q  <= resume_d;
`endif
    end
  end

  // In DONE the Index output keeps showing the final entry that was played.
  assign CtrlWord = cw_q;
  assign Index    = idx_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
`ifdef CTRL_SEQ_BRK_EN
  assign BrkHit   = brk_hit_q;
`endif

endmodule

// File: tb/tb_ctrl_seq_player.sv
// Testbench for ctrl_seq_player: scenario tasks with a per-cycle expected queue of
// {Busy, Done, Index, CtrlWord} built from a bench-side copy of the table.
module tb_ctrl_seq_player;
  localparam int DEPTH = 16;
  localparam int HOLD_W = 8;
  localparam int CW_W = 7;
  localparam int STAT_W = 4;
  localparam int AW = 4;
  localparam int EW = 2 + AW + CW_W;
  localparam logic [CW_W-1:0] IDLE_CW = 7'h08;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wr_en = 1'b0;
  logic [AW-1:0]          wr_addr = '0;
  logic [CW_W+HOLD_W-1:0] wr_data = '0;
  logic                   start = 1'b0;
  logic                   stop = 1'b0;
  logic                   loop = 1'b0;
  logic [AW-1:0]          last_idx = '0;
  logic [STAT_W-1:0]      status = '0;
  logic [CW_W-1:0]        ctrl_word;
  logic [AW-1:0]          index;
  logic                   busy;
  logic                   done;
`ifdef CTRL_SEQ_BRK_EN
  logic [STAT_W-1:0]      brk_mask = '0;
  logic [STAT_W-1:0]      brk_val = '0;
  logic                   brk_hit;
`endif

  ctrl_seq_player dut (
    .Clock(clk), .Reset(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .Start(start), .Stop(stop), .Loop(loop), .LastIdx(last_idx), .Status(status),
`ifdef CTRL_SEQ_BRK_EN
    .BrkMask(brk_mask), .BrkVal(brk_val), .BrkHit(brk_hit),
`endif
    .CtrlWord(ctrl_word), .Index(index), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  logic [EW-1:0]     exp_q[$];
  logic [HOLD_W-1:0] m_hold [DEPTH];
  logic [CW_W-1:0]   m_cw [DEPTH];
  int passed = 0;
  int total = 0;

  function automatic logic [EW-1:0] mk(logic b, logic d, logic [AW-1:0] ix, logic [CW_W-1:0] c);
    return {b, d, ix, c};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {busy, done, index, ctrl_word};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int h, input int c);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = {HOLD_W'(h), CW_W'(c)};
    m_hold[a] = HOLD_W'(h);
    m_cw[a] = CW_W'(c);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_entry(input int i);
    for (int r = 0; r <= int'(m_hold[i]); r++) exp_q.push_back(mk(1'b1, 1'b0, AW'(i), m_cw[i]));
  endtask

  task automatic pulse_start(input int last, input logic lp);
    last_idx = AW'(last);
    loop = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] got;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      got = obs();
      total++;
      if (got !== mk(1'b0, 1'b0, '0, IDLE_CW))
        $display("FAIL reset cyc=%0d got=%h exp=%h", k, got, mk(1'b0, 1'b0, '0, IDLE_CW));
      else passed++;
      tick();
    end
  endtask

  task automatic test_oneshot();
    logic [EW-1:0] got, exp;
    int k = 0;
    wr(0, 0, 'h28);
    wr(1, 2, 'h11);
    wr(2, 0, 'h48);
    for (int i = 0; i < 3; i++) push_entry(i);
    exp_q.push_back(mk(1'b0, 1'b1, AW'(2), IDLE_CW));
    exp_q.push_back(mk(1'b0, 1'b1, AW'(2), IDLE_CW));
    pulse_start(2, 1'b0);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs();
      total++;
      if (got !== exp) $display("FAIL oneshot cyc=%0d got=%h exp=%h", k, got, exp);
      else passed++;
      k++;
      if (exp_q.size() > 0) tick();
    end
  endtask

  task automatic test_loop_stop();
    logic [EW-1:0] got, exp;
    int k = 0;
    for (int i = 0; i < 3; i++) push_entry(i);
    push_entry(0);
    exp_q.push_back(mk(1'b1, 1'b0, AW'(1), m_cw[1]));
    exp_q.push_back(mk(1'b1, 1'b0, AW'(1), m_cw[1]));
    pulse_start(2, 1'b1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs();
      total++;
      if (got !== exp) $display("FAIL loop cyc=%0d got=%h exp=%h", k, got, exp);
      else passed++;
      k++;
      if (exp_q.size() > 0) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    for (int j = 0; j < 2; j++) begin
      got = obs();
      total++;
      if (got !== mk(1'b0, 1'b0, '0, IDLE_CW))
        $display("FAIL stop_idle cyc=%0d got=%h exp=%h", j, got, mk(1'b0, 1'b0, '0, IDLE_CW));
      else passed++;
      tick();
    end
  endtask

  task automatic test_start_stop_same();
    logic [EW-1:0] got;
    last_idx = AW'(2);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    for (int j = 0; j < 2; j++) begin
      got = obs();
      total++;
      if (got !== mk(1'b0, 1'b0, '0, IDLE_CW))
        $display("FAIL start_stop cyc=%0d got=%h exp=%h", j, got, mk(1'b0, 1'b0, '0, IDLE_CW));
      else passed++;
      tick();
    end
  endtask

  task automatic test_start_in_run();
    logic [EW-1:0] got, exp;
    int k = 0;
    for (int i = 0; i < 3; i++) push_entry(i);
    exp_q.push_back(mk(1'b0, 1'b1, AW'(2), IDLE_CW));
    pulse_start(2, 1'b0);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs();
      total++;
      if (got !== exp) $display("FAIL start_in_run cyc=%0d got=%h exp=%h", k, got, exp);
      else passed++;
      if (k == 2 || k == 4) start = 1'b1;
      k++;
      if (exp_q.size() > 0) tick();
      start = 1'b0;
    end
  endtask

  task automatic test_full_table();
    logic [EW-1:0] got, exp;
    int k = 0;
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 2), $urandom_range(0, 127));
    for (int i = 0; i < DEPTH; i++) push_entry(i);
    exp_q.push_back(mk(1'b0, 1'b1, AW'(DEPTH - 1), IDLE_CW));
    // Largest LastIdx the port can carry; a wider request like 31 reaches the port truncated.
    pulse_start(DEPTH - 1, 1'b0);
    last_idx = '1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs();
      total++;
      if (got !== exp) $display("FAIL full_table cyc=%0d got=%h exp=%h", k, got, exp);
      else passed++;
      k++;
      if (exp_q.size() > 0) tick();
    end
  endtask

  task automatic test_live_write();
    logic [EW-1:0] got, exp;
    int k = 0;
    wr(0, 0, 'h28);
    wr(1, 2, 'h11);
    wr(2, 0, 'h48);
    for (int i = 0; i < 3; i++) push_entry(i);
    push_entry(0);
    pulse_start(2, 1'b1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs();
      total++;
      if (got !== exp) $display("FAIL live_write cyc=%0d got=%h exp=%h", k, got, exp);
      else passed++;
      if (k == 1) begin
        wr_en = 1'b1;
        wr_addr = AW'(1);
        wr_data = {HOLD_W'(0), CW_W'('h33)};
        m_hold[1] = '0;
        m_cw[1] = 7'h33;
        push_entry(1);
        push_entry(2);
      end
      k++;
      if (exp_q.size() > 0) tick();
      wr_en = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] got;
    pulse_start(2, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    loop = 1'b0;
    got = obs();
    total++;
    if (got !== mk(1'b0, 1'b0, '0, IDLE_CW))
      $display("FAIL reset_mid got=%h exp=%h", got, mk(1'b0, 1'b0, '0, IDLE_CW));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop_stop();
    test_start_stop_same();
    test_start_in_run();
    test_full_table();
    test_live_write();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
